// File: rtl/blockstacker_pkg.sv
// Shared screen geometry and draw FSM state encoding for the block-stacker display path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blockstacker_pkg;

   // Visible framebuffer size; anything at or beyond these coordinates is clipped.
   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } draw_state_t;

endpackage

// File: rtl/block_offset_counter.sv
// Row-major (cx, cy) offset walker over a BLOCK_W x BLOCK_H block with a last-pixel flag.
// Latency: offsets advance one step per cycle while step is high; last is combinational from the count.
// Backpressure: none; the owner holds step low to pause.
module block_offset_counter #(
   parameter int unsigned BLOCK_W = 4,
   parameter int unsigned BLOCK_H = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       step,
   output logic [3:0] cx,
   output logic [3:0] cy,
   output logic       last
);

   localparam logic [3:0] CX_MAX = 4'(BLOCK_W - 1);
   localparam logic [3:0] CY_MAX = 4'(BLOCK_H - 1);

   // Final pixel of the block is the bottom-right corner.
   assign last = (cx == CX_MAX) && (cy == CY_MAX);

   // x varies fastest; both offsets wrap to zero after the last pixel.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cx <= 4'd0;
         cy <= 4'd0;
      end else if (step) begin
         if (cx == CX_MAX) begin
            cx <= 4'd0;
            cy <= (cy == CY_MAX) ? 4'd0 : cy + 4'd1;
         end else begin
            cx <= cx + 4'd1;
         end
      end
   end

endmodule

// File: rtl/draw_block.sv
// Plots one BLOCK_W x BLOCK_H block at (x_in, y_in) onto the VGA write port, one pixel per clock.
// Latency: start taken at edge N -> first plot after N+1, last after N+W*H, done after N+W*H+1.
// Backpressure: none; start is ignored (not queued) while busy and during the done pulse.
module draw_block
   import blockstacker_pkg::*;
#(
   parameter int unsigned BLOCK_W  = 4,
   parameter int unsigned BLOCK_H  = 4,
   parameter int unsigned SCREEN_W = blockstacker_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H = blockstacker_pkg::SCREEN_H
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] x_in,
   input  logic [6:0] y_in,
   input  logic [2:0] colour_in,
   output logic       busy,
   output logic       done,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour
);

   // Clip limits sized to the one-bit-wider coordinate sums.
   localparam logic [8:0] X_LIM = 9'(SCREEN_W);
   localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

   draw_state_t state;
   draw_state_t state_nxt;

   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [2:0] base_colour;

   logic [3:0] cx;
   logic [3:0] cy;
   logic       last_px;

   logic       accept;
   logic       in_draw;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic       clip;

   // The done output lags the internal DONE state by one cycle, so a start that
   // coincides with the visible done pulse is refused as well.
   assign accept  = (state == IDLE) && start && !done;
   assign in_draw = (state == DRAW);

   // Sums are one bit wider so off-screen pixels are detected rather than wrapped.
   assign sum_x = {1'b0, base_x} + {5'b0, cx};
   assign sum_y = {1'b0, base_y} + {4'b0, cy};
   assign clip  = (sum_x >= X_LIM) || (sum_y >= Y_LIM);

   block_offset_counter #(
      .BLOCK_W (BLOCK_W),
      .BLOCK_H (BLOCK_H)
   ) u_offset (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .step  (in_draw),
      .cx    (cx),
      .cy    (cy),
      .last  (last_px)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: one pass over the block, then a single done cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)  state_nxt = DRAW;
         DRAW:    if (last_px) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the placement on accept so upstream may change its inputs freely afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_x      <= 8'd0;
         base_y      <= 7'd0;
         base_colour <= 3'd0;
      end else if (accept) begin
         base_x      <= x_in;
         base_y      <= y_in;
         base_colour <= colour_in;
      end
   end

   // Registered VGA port and status; coordinates track every drawn pixel, clipped or not.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         plot       <= 1'b0;
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'd0;
      end else begin
         busy <= (state != IDLE);
         done <= (state == DONE);
         plot <= in_draw && !clip;
         if (in_draw) begin
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= base_colour;
         end
      end
   end

endmodule

// File: tb/tb_draw_block.sv
module tb_draw_block;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] colour_in;
   logic       busy;
   logic       done;
   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int n_tests = 0;
   int n_fail  = 0;

   draw_block dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .x_in       (x_in),
      .y_in       (y_in),
      .colour_in  (colour_in),
      .busy       (busy),
      .done       (done),
      .plot       (plot),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " plot"},   32'(plot),       32'd0);
      chk({nm, " busy"},   32'(busy),       32'd0);
      chk({nm, " done"},   32'(done),       32'd0);
      chk({nm, " x"},      32'(vga_x),      32'd0);
      chk({nm, " y"},      32'(vga_y),      32'd0);
      chk({nm, " colour"}, 32'(vga_colour), 32'd0);
   endtask

   // Drives one block (unless start is already high) and checks every cycle from
   // acceptance through the cycle after the done pulse.
   task automatic run_block(input string nm, input logic [7:0] x, input logic [6:0] y,
                            input logic [2:0] c, input bit start_high, input bit inject,
                            input bit chain, input logic [7:0] nx, input logic [6:0] ny,
                            input logic [2:0] nc, input int exp_plots);
      int         plots    = 0;
      int         busy_cnt = 0;
      logic [8:0] ex;
      logic [7:0] ey;
      logic       ep;
      if (!start_high) begin
         @(negedge clk);
         start = 1'b1; x_in = x; y_in = y; colour_in = c;
      end
      @(negedge clk);
      // edge N has passed; scramble inputs to prove the placement was latched
      start = 1'b0; x_in = 8'hA5; y_in = 7'h2A; colour_in = ~c;
      busy_cnt += int'(busy);
      chk({nm, " plot_n0"}, 32'(plot), 32'd0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (inject && k == 3) begin
            start = 1'b1; x_in = 8'd40; y_in = 7'd40; colour_in = ~c;
         end
         if (inject && k == 6) start = 1'b0;
         ex = {1'b0, x} + 9'(k % 4);
         ey = {1'b0, y} + 8'(k / 4);
         ep = (ex < 9'd160) && (ey < 8'd120);
         chk($sformatf("%s plot%0d", nm, k),   32'(plot),       32'(ep));
         chk($sformatf("%s x%0d", nm, k),      32'(vga_x),      32'(ex[7:0]));
         chk($sformatf("%s y%0d", nm, k),      32'(vga_y),      32'(ey[6:0]));
         chk($sformatf("%s col%0d", nm, k),    32'(vga_colour), 32'(c));
         chk($sformatf("%s done_px%0d", nm, k), 32'(done),      32'd0);
         plots    += int'(plot);
         busy_cnt += int'(busy);
      end
      @(negedge clk);
      chk({nm, " done_pulse"}, 32'(done), 32'd1);
      chk({nm, " done_plot"},  32'(plot), 32'd0);
      busy_cnt += int'(busy);
      if (chain) begin
         start = 1'b1; x_in = nx; y_in = ny; colour_in = nc;
      end
      @(negedge clk);
      chk({nm, " done_end"}, 32'(done), 32'd0);
      chk({nm, " busy_end"}, 32'(busy), 32'd0);
      busy_cnt += int'(busy);
      chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd17);
      chk({nm, " plot_count"},  32'(plots),    32'(exp_plots));
   endtask

   initial begin
      int cnt_plot;
      int cnt_done;
      int cnt_busy;
      reset = 1'b1; start = 1'b0; x_in = 8'd0; y_in = 7'd0; colour_in = 3'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b0;

      // 1: bottom rows, fully visible
      run_block("t1", 8'd8, 7'd116, 3'b100, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 16);
      // 2: right edge reaches x=159, no clipping
      run_block("t2", 8'd156, 7'd116, 3'b001, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 16);
      // 3: bottom-right corner, only a 2x2 quarter visible
      run_block("t3", 8'd158, 7'd118, 3'b010, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 4);
      // 4: start pulses mid-draw ignored; start held through done then accepted
      run_block("t4", 8'd60, 7'd50, 3'b011, 1'b0, 1'b1, 1'b1, 8'd100, 7'd20, 3'b110, 16);
      run_block("t4b", 8'd100, 7'd20, 3'b110, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 16);

      // 5: reset while the 7th pixel is on the port
      @(negedge clk);
      start = 1'b1; x_in = 8'd20; y_in = 7'd30; colour_in = 3'b010;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk($sformatf("t5 plot%0d", k), 32'(plot),  32'd1);
         chk($sformatf("t5 x%0d", k),    32'(vga_x), 32'(20 + k % 4));
      end
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("t5 abort");
      reset = 1'b0;
      cnt_plot = 0; cnt_done = 0; cnt_busy = 0;
      repeat (20) begin
         @(negedge clk);
         cnt_plot += int'(plot);
         cnt_done += int'(done);
         cnt_busy += int'(busy);
      end
      chk("t5 post_plot", 32'(cnt_plot), 32'd0);
      chk("t5 post_done", 32'(cnt_done), 32'd0);
      chk("t5 post_busy", 32'(cnt_busy), 32'd0);

      // 6: erase at the origin
      run_block("t6", 8'd0, 7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 16);
      // 7: sums overflow the port width; all clipped, truncated coordinates still shown
      run_block("t7", 8'd254, 7'd126, 3'b101, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
